// File: rtl/fp_addsub_result_buffer.sv
// Result buffer behind the FP add/sub unit: classifies each accepted result word,
// queues it in a small FIFO, and keeps sticky exception flags plus a popped-result count.
module fp_addsub_result_buffer #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_op,
  output logic             out_sign,
  output logic [2:0]       out_class,
  output logic [LVL_W-1:0] level,
  output logic             flag_nan,
  output logic             flag_inf,
  output logic             flag_denorm,
  input  logic             flags_clr,
  output logic [CNT_W-1:0] result_cnt
);

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } fp_class_e;

  logic [WIDTH-1:0] data_mem  [DEPTH];
  logic             op_mem    [DEPTH];
  logic             sign_mem  [DEPTH];
  fp_class_e        class_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  fp_class_e     in_class;

  function automatic fp_class_e classify(input logic [WIDTH-1:0] w);
    logic [EXP_BITS-1:0]  e;
    logic [MANT_BITS-1:0] m;
    e = w[WIDTH-2 -: EXP_BITS];
    m = w[MANT_BITS-1:0];
    if (e == '0)                 return (m == '0) ? CLS_ZERO : CLS_DENORM;
    else if (e != '1)            return CLS_NORMAL;
    else if (m == '0)            return CLS_INF;
    else if (m[MANT_BITS-1])     return CLS_QNAN;
    else                         return CLS_SNAN;
  endfunction

  assign in_class  = classify(in_result);
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign out_result = out_valid ? data_mem[rd_ptr]  : '0;
  assign out_op     = out_valid ? op_mem[rd_ptr]    : 1'b0;
  assign out_sign   = out_valid ? sign_mem[rd_ptr]  : 1'b0;
  assign out_class  = out_valid ? class_mem[rd_ptr] : 3'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= in_result;
      op_mem[wr_ptr]    <= in_op;
      sign_mem[wr_ptr]  <= in_result[WIDTH-1];
      class_mem[wr_ptr] <= in_class;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // A flag being set by this cycle's push takes priority over a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_nan    <= 1'b0;
      flag_inf    <= 1'b0;
      flag_denorm <= 1'b0;
    end else begin
      if (push && (in_class == CLS_QNAN || in_class == CLS_SNAN)) flag_nan <= 1'b1;
      else if (flags_clr)                                       flag_nan <= 1'b0;
      if (push && in_class == CLS_INF)    flag_inf <= 1'b1;
      else if (flags_clr)                 flag_inf <= 1'b0;
      if (push && in_class == CLS_DENORM) flag_denorm <= 1'b1;
      else if (flags_clr)                 flag_denorm <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (pop && result_cnt != '1) begin
      result_cnt <= result_cnt + CNT_W'(1);
    end
  end

endmodule
